attack_resolver: RTL and testbench
==================================

# attack_resolver

Combat-resolution stage directly downstream of collision detection. Turns debounced attack buttons into timed attacks for both players and samples the registered hit-range flag at the strike instant. Applies saturating damage to the opponent's health and latches game-over and winner. Health and attack-state outputs feed the health-bar renderer and the sprite selector.

## Interface
Parameters:
- MAX_HEALTH, 100: health at reset; must be ≤ 127.
- DAMAGE, 10: health removed per landed strike.
- WINDUP_TICKS, 3: ticks spent in WINDUP; must be ≥ 1.
- RECOVER_TICKS, 8: ticks spent in RECOVER; must be ≥ 1.

Ports:
- clk  in  1  system clock. The block uses one clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle frame-rate enable pulse.
- p1_attack_btn  in  1  player 1 attack button, already synchronised and debounced.
- p2_attack_btn  in  1  player 2 attack button, already synchronised and debounced.
- in_hitrange  in  1  registered hit-range flag from collision detection. The distance is symmetric, so one flag serves both players.
- p1_health  out  7  player 1 health.
- p2_health  out  7  player 2 health.
- p1_attacking  out  1  high while player 1 is in WINDUP or STRIKE.
- p2_attacking  out  1  high while player 2 is in WINDUP or STRIKE.
- p1_hit_pulse  out  1  one-cycle pulse when player 1 takes damage.
- p2_hit_pulse  out  1  one-cycle pulse when player 2 takes damage.
- game_over  out  1  latched high once either health reaches 0.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

## Operation
- Each player has an independent FSM: IDLE → WINDUP → STRIKE → RECOVER → IDLE.
- A rising edge on a button (high now, low the previous cycle) starts an attack, but only when that player is in IDLE.
  - Edges seen in any other state are dropped, not queued.
- WINDUP:
  - The counter loads WINDUP_TICKS on entry and decrements on each tick.
  - When a tick arrives with counter == 1, the FSM moves to STRIKE.
- STRIKE lasts exactly one cycle.
  - If in_hitrange == 1 in that cycle, the strike lands on the opponent. Otherwise it misses.
  - The FSM always continues to RECOVER.
- RECOVER loads RECOVER_TICKS and counts down like WINDUP, then returns to IDLE.
- Damage rule: new health = (health > DAMAGE) ? health − DAMAGE : 0. Health never wraps and never increases.
- Simultaneous strikes in the same cycle both land if in_hitrange == 1. Each player's health updates independently on the same edge.
- Game over:
  - game_over sets on the edge where either health becomes 0.
  - winner is set on that same edge: 01 if only P2 reached 0, 10 if only P1 reached 0, 11 if both reached 0 on that edge.
  - While game_over is high, both FSMs are held in IDLE, button edges are ignored, and health is frozen. Only reset clears this.
- in_hitrange is sampled only in STRIKE. Its pipeline latency upstream is irrelevant outside that cycle.

## Timing
- Reset values: p1_health = p2_health = MAX_HEALTH; both FSMs IDLE; counters 0; attacking = 0; hit pulses = 0; game_over = 0; winner = 00; edge-detect registers 0.
- Reset mid-attack aborts the attack on the next edge. A strike pending in that cycle is discarded.
- Button edge present at cycle t → WINDUP from t+1. p_attacking is high from t+1.
- Total attack duration is WINDUP_TICKS ticks + 1 cycle + RECOVER_TICKS ticks.
- A STRIKE at cycle s with a hit produces:
  - opponent health updated at s+1;
  - opponent hit_pulse high for cycle s+1 only;
  - game_over/winner, if applicable, valid at s+1.
- A tick during the STRIKE cycle is not counted toward RECOVER.
- p_attacking drops in the first RECOVER cycle.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `fighter_pkg` holds:
  - FSM state enum (IDLE, WINDUP, STRIKE, RECOVER);
  - winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW);
  - health width constant (7).
- Sub-module `attack_fsm` is instantiated once per player. It contains:
  - button edge detect, state register, and tick counter;
  - a `freeze` input and the `in_hitrange` input;
  - outputs: `attacking` and a one-cycle `strike_hit`.
- The top level holds the health registers, the damage saturation logic, hit pulses, and the game-over/winner latch.

## Test plan
- Reset, then P1 presses with in_hitrange = 1 and defaults → after 3 ticks, STRIKE for one cycle. p2_health = 90 and p2_hit_pulse is high for one cycle, both on the edge after STRIKE. p1_health stays 100.
- P1 attacks with in_hitrange = 0 for the whole STRIKE → no health change, no pulse. FSM still passes through RECOVER (8 ticks) to IDLE.
- P1 presses again during WINDUP and during RECOVER → ignored. Exactly one strike occurs. A held-high button does not retrigger.
- Both players press on the same cycle with in_hitrange = 1 → both healths read 90 on the same edge, and both hit pulses are asserted together.
- Set DAMAGE = 30 and land 4 P1 strikes → p2_health goes 70, 40, 10, 0 with no wrap. game_over = 1 and winner = 01 appear with the 0. Subsequent presses by either player change nothing.
- Both players at 10 health land simultaneous strikes → winner = 11. Then assert reset mid-WINDUP → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared types for the fighter combat pipeline: attack FSM states,
// winner codes and the health width used by the resolver.
package fighter_pkg;

    localparam int HEALTH_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        WINDUP,
        STRIKE,
        RECOVER
    } atk_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    function automatic logic [HEALTH_W-1:0] sat_damage(
        input logic [HEALTH_W-1:0] health,
        input logic [HEALTH_W-1:0] dmg
    );
        return (health > dmg) ? health - dmg : '0;
    endfunction

endpackage

// File: rtl/attack_fsm.sv
// Per-player attack sequencer: button edge detect, tick-timed
// WINDUP/RECOVER phases and a one-cycle STRIKE sampling hit range.
module attack_fsm
    import fighter_pkg::*;
#(
    parameter int WINDUP_TICKS  = 3,
    parameter int RECOVER_TICKS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    input  logic freeze,
    input  logic in_hitrange,
    output logic attacking,
    output logic strike_hit
);

    localparam int CNT_MAX = (WINDUP_TICKS > RECOVER_TICKS) ?
                             WINDUP_TICKS : RECOVER_TICKS;
    localparam int CW = $clog2(CNT_MAX + 1);

    atk_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_btn_d;
    logic          r_attacking;
    logic          w_rise;
    logic          w_last;

    assign w_rise = btn & ~r_btn_d;
    assign w_last = tick && (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_btn_d     <= 1'b0;
            r_attacking <= 1'b0;
        end else begin
            r_btn_d <= btn;
            if (freeze) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_attacking <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state     <= WINDUP;
                            r_cnt       <= CW'(WINDUP_TICKS);
                            r_attacking <= 1'b1;
                        end
                    end
                    WINDUP: begin
                        if (w_last) begin
                            r_state <= STRIKE;
                            r_cnt   <= '0;
                        end else if (tick) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    // Ticks landing on the strike cycle are not counted.
                    STRIKE: begin
                        r_state     <= RECOVER;
                        r_cnt       <= CW'(RECOVER_TICKS);
                        r_attacking <= 1'b0;
                    end
                    RECOVER: begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (tick) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_attacking <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign attacking  = r_attacking;
    assign strike_hit = (r_state == STRIKE) & in_hitrange & ~freeze;

endmodule

// File: rtl/attack_resolver.sv
// Combat resolution: two attack sequencers, saturating health,
// hit pulses and the game-over/winner latch.
module attack_resolver
    import fighter_pkg::*;
#(
    parameter int MAX_HEALTH    = 100,
    parameter int DAMAGE        = 10,
    parameter int WINDUP_TICKS  = 3,
    parameter int RECOVER_TICKS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                p1_attack_btn,
    input  logic                p2_attack_btn,
    input  logic                in_hitrange,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_attacking,
    output logic                p2_attacking,
    output logic                p1_hit_pulse,
    output logic                p2_hit_pulse,
    output logic                game_over,
    output logic [1:0]          winner
);

    localparam logic [HEALTH_W-1:0] MAX_H = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DMG   = HEALTH_W'(DAMAGE);

    logic [HEALTH_W-1:0] r_p1_health;
    logic [HEALTH_W-1:0] r_p2_health;
    logic                r_p1_hit;
    logic                r_p2_hit;
    logic                r_game_over;
    winner_t             r_winner;

    logic                w_p1_strike;
    logic                w_p2_strike;
    logic [HEALTH_W-1:0] w_p1_next;
    logic [HEALTH_W-1:0] w_p2_next;
    logic                w_p1_dead;
    logic                w_p2_dead;

    attack_fsm #(
        .WINDUP_TICKS (WINDUP_TICKS),
        .RECOVER_TICKS(RECOVER_TICKS)
    ) u_p1 (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn        (p1_attack_btn),
        .freeze     (r_game_over),
        .in_hitrange(in_hitrange),
        .attacking  (p1_attacking),
        .strike_hit (w_p1_strike)
    );

    attack_fsm #(
        .WINDUP_TICKS (WINDUP_TICKS),
        .RECOVER_TICKS(RECOVER_TICKS)
    ) u_p2 (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn        (p2_attack_btn),
        .freeze     (r_game_over),
        .in_hitrange(in_hitrange),
        .attacking  (p2_attacking),
        .strike_hit (w_p2_strike)
    );

    // A player's health drops when the opponent's strike lands.
    assign w_p1_next = w_p2_strike ? sat_damage(r_p1_health, DMG)
                                   : r_p1_health;
    assign w_p2_next = w_p1_strike ? sat_damage(r_p2_health, DMG)
                                   : r_p2_health;
    assign w_p1_dead = (w_p1_next == '0);
    assign w_p2_dead = (w_p2_next == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_health <= MAX_H;
            r_p2_health <= MAX_H;
            r_p1_hit    <= 1'b0;
            r_p2_hit    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_p1_hit <= w_p2_strike;
            r_p2_hit <= w_p1_strike;
            if (!r_game_over) begin
                r_p1_health <= w_p1_next;
                r_p2_health <= w_p2_next;
                if (w_p1_dead || w_p2_dead) begin
                    r_game_over <= 1'b1;
                    if (w_p1_dead && w_p2_dead)
                        r_winner <= WIN_DRAW;
                    else if (w_p2_dead)
                        r_winner <= WIN_P1;
                    else
                        r_winner <= WIN_P2;
                end
            end
        end
    end

    assign p1_health    = r_p1_health;
    assign p2_health    = r_p2_health;
    assign p1_hit_pulse = r_p1_hit;
    assign p2_hit_pulse = r_p2_hit;
    assign game_over    = r_game_over;
    assign winner       = r_winner;

endmodule

// File: tb/tb_attack_resolver.sv
// Bench for attack_resolver: two instances (DAMAGE 10 and 30) on shared
// stimulus, compared each cycle against a tick-counting timeline model.
module tb_attack_resolver;

    localparam int W    = 3;
    localparam int R    = 8;
    localparam int MAXH = 100;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       b1;
    logic       b2;
    logic       hr;
    logic [6:0] p1h [2];
    logic [6:0] p2h [2];
    logic       p1a [2];
    logic       p2a [2];
    logic       p1p [2];
    logic       p2p [2];
    logic       go  [2];
    logic [1:0] win [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   dmg    [2] = '{10, 30};
    int   mh     [2][2];
    bit   mgo    [2];
    int   mwin   [2];
    bit   mpul   [2][2];
    bit   busy   [2][2];
    int   tc     [2][2];
    bit   struck [2][2];
    bit   prevb  [2][2];

    attack_resolver #(
        .MAX_HEALTH(MAXH), .DAMAGE(10),
        .WINDUP_TICKS(W), .RECOVER_TICKS(R)
    ) u_d10 (
        .clk(clk), .reset(reset), .tick(tick),
        .p1_attack_btn(b1), .p2_attack_btn(b2),
        .in_hitrange(hr),
        .p1_health(p1h[0]), .p2_health(p2h[0]),
        .p1_attacking(p1a[0]), .p2_attacking(p2a[0]),
        .p1_hit_pulse(p1p[0]), .p2_hit_pulse(p2p[0]),
        .game_over(go[0]), .winner(win[0])
    );

    attack_resolver #(
        .MAX_HEALTH(MAXH), .DAMAGE(30),
        .WINDUP_TICKS(W), .RECOVER_TICKS(R)
    ) u_d30 (
        .clk(clk), .reset(reset), .tick(tick),
        .p1_attack_btn(b1), .p2_attack_btn(b2),
        .in_hitrange(hr),
        .p1_health(p1h[1]), .p2_health(p2h[1]),
        .p1_attacking(p1a[1]), .p2_attacking(p2a[1]),
        .p1_hit_pulse(p1p[1]), .p2_hit_pulse(p2p[1]),
        .game_over(go[1]), .winner(win[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [20:0] obs,
                       input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    // Timeline model: an attack is a run of W ticks, one strike cycle,
    // then R more ticks; tc counts ticks seen since the press.
    task automatic model_edge(input bit rst, input bit bt0,
                              input bit bt1, input bit tk,
                              input bit h);
        bit bt [2];
        bt[0] = bt0;
        bt[1] = bt1;
        for (int k = 0; k < 2; k++) begin
            bit go_old;
            bit sn   [2];
            bit land [2];
            int nh   [2];
            go_old = mgo[k];
            if (rst) begin
                mgo[k]  = 1'b0;
                mwin[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    mh[k][p]     = MAXH;
                    mpul[k][p]   = 1'b0;
                    busy[k][p]   = 1'b0;
                    tc[k][p]     = 0;
                    struck[k][p] = 1'b0;
                    prevb[k][p]  = 1'b0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    sn[p] = busy[k][p] && !struck[k][p] && tc[k][p] == W;
                    land[p] = sn[p] && h && !go_old;
                end
                for (int p = 0; p < 2; p++) begin
                    mpul[k][p] = land[1-p];
                    if (land[1-p])
                        nh[p] = (mh[k][p] - dmg[k] < 0) ? 0
                              : mh[k][p] - dmg[k];
                    else
                        nh[p] = mh[k][p];
                end
                if (!go_old) begin
                    mh[k][0] = nh[0];
                    mh[k][1] = nh[1];
                    if (nh[0] == 0 || nh[1] == 0) begin
                        mgo[k] = 1'b1;
                        if (nh[0] == 0 && nh[1] == 0) mwin[k] = 3;
                        else if (nh[1] == 0)          mwin[k] = 1;
                        else                          mwin[k] = 2;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (go_old) begin
                        busy[k][p] = 1'b0;
                    end else if (sn[p]) begin
                        struck[k][p] = 1'b1;
                    end else if (busy[k][p]) begin
                        if (tk) begin
                            tc[k][p]++;
                            if (tc[k][p] == W + R) busy[k][p] = 1'b0;
                        end
                    end else if (bt[p] && !prevb[k][p]) begin
                        busy[k][p]   = 1'b1;
                        tc[k][p]     = 0;
                        struck[k][p] = 1'b0;
                    end
                    prevb[k][p] = bt[p];
                end
            end
        end
    endtask

    function automatic logic [20:0] exp_vec(input int k);
        return {7'(mh[k][0]), 7'(mh[k][1]),
                busy[k][0] && !struck[k][0],
                busy[k][1] && !struck[k][1],
                mpul[k][0], mpul[k][1], mgo[k], 2'(mwin[k])};
    endfunction

    function automatic logic [20:0] obs_vec(input int k);
        return {p1h[k], p2h[k], p1a[k], p2a[k],
                p1p[k], p2p[k], go[k], win[k]};
    endfunction

    task automatic step(input bit rst, input bit x1, input bit x2,
                        input bit tk, input bit h);
        reset = rst;
        b1    = x1;
        b2    = x2;
        tick  = tk;
        hr    = h;
        @(posedge clk);
        model_edge(rst, x1, x2, tk, h);
        #1;
        chk("d10", obs_vec(0), exp_vec(0));
        chk("d30", obs_vec(1), exp_vec(1));
        cyc++;
    endtask

    task automatic run(input int n, input bit x1, input bit x2,
                       input bit h);
        for (int i = 0; i < n; i++)
            step(1'b0, x1, x2, (cyc % 3) == 0, h);
    endtask

    task automatic press(input bit x1, input bit x2, input bit h);
        step(1'b0, x1, x2, (cyc % 3) == 0, h);
        run(45, 1'b0, 1'b0, h);
    endtask

    initial begin
        reset = 1'b1;
        b1    = 1'b0;
        b2    = 1'b0;
        tick  = 1'b0;
        hr    = 1'b0;
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_state", obs_vec(0),
            {7'd100, 7'd100, 7'b0_0_0_0_0_00});

        // Single landed strike, then a miss.
        press(1, 0, 1);
        chk("hit_p2", 21'(p2h[0]), 21'd90);
        chk("hit_p1", 21'(p1h[0]), 21'd100);
        press(1, 0, 0);
        chk("miss_p2", 21'(p2h[0]), 21'd90);

        // Re-press in WINDUP, edge in RECOVER, then held high.
        step(0, 1, 0, (cyc % 3) == 0, 1);
        run(4, 0, 0, 1);
        step(0, 1, 0, (cyc % 3) == 0, 1);
        run(15, 0, 0, 1);
        run(30, 1, 0, 1);
        run(5, 0, 0, 1);
        chk("one_strike", 21'(p2h[0]), 21'd80);
        chk("d30_p2_40", 21'(p2h[1]), 21'd40);

        // DAMAGE=30 instance reaches 0 without wrapping.
        press(1, 0, 1);
        chk("d30_p2_10", 21'(p2h[1]), 21'd10);
        press(1, 0, 1);
        chk("d30_p2_0", 21'(p2h[1]), 21'd0);
        chk("d30_win_p1", 21'({go[1], win[1]}), 21'b1_01);
        press(0, 1, 1);
        press(1, 1, 1);
        chk("d30_frozen", 21'({p1h[1], p2h[1]}), 21'({7'd100, 7'd0}));
        chk("d10_live", 21'({p1h[0], p2h[0]}), 21'({7'd80, 7'd50}));

        // Simultaneous strikes to a draw.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) press(1, 1, 1);
        chk("d10_both10", 21'({p1h[0], p2h[0], go[0]}),
            21'({7'd10, 7'd10, 1'b0}));
        chk("d30_draw", 21'({go[1], win[1]}), 21'b1_11);
        press(1, 1, 1);
        chk("d10_draw", 21'({p1h[0], p2h[0], go[0], win[0]}),
            21'({7'd0, 7'd0, 1'b1, 2'b11}));

        // Reset while in WINDUP.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        run(2, 0, 0, 1);
        chk("windup_att", 21'(p1a[0]), 21'd1);
        step(1, 0, 0, 1, 1);
        chk("rst_mid", obs_vec(0),
            {7'd100, 7'd100, 7'b0_0_0_0_0_00});

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 400) == 0,
                 ($urandom % 8) == 0,
                 ($urandom % 8) == 0,
                 ($urandom % 3) == 0,
                 $urandom % 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
